// File: rtl/operand_fetch.sv
// operand_fetch: issue-stage operand resolution with a register scoreboard.
//
// An instruction offered on in_* has its source operands read from an
// external register file. A same-cycle writeback is forwarded into the
// operands. A 32-entry busy scoreboard tracks destinations with results
// still outstanding. One output register stage holds the resolved bundle
// until downstream accepts it.
//
// Ports:
//   clock, ctrl_reset          clock; asynchronous active-high reset
//   in_valid/in_ready          instruction handshake (in_rs1, in_rs2, in_rd, in_wen)
//   out_valid/out_ready        bundle handshake (out_opA, out_opB, out_rd, out_wen)
//   wb_valid, wb_rd, wb_data   writeback request (forwarded and written to regfile)
//   ctrl_readRegA/B            register file read selects (combinational)
//   data_readRegA/B            register file read data (combinational)
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg   register file write port
module operand_fetch #(
  localparam int unsigned XLEN = 32,
  localparam int unsigned AW   = 5,
  localparam int unsigned NREG = 32
) (
  input  logic            clock,
  input  logic            ctrl_reset,
  input  logic            in_valid,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_wen,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_opA,
  output logic [XLEN-1:0] out_opB,
  output logic [AW-1:0]   out_rd,
  output logic            out_wen,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW-1:0]   ctrl_readRegA,
  output logic [AW-1:0]   ctrl_readRegB,
  input  logic [XLEN-1:0] data_readRegA,
  input  logic [XLEN-1:0] data_readRegB,
  output logic            ctrl_writeEnable,
  output logic [AW-1:0]   ctrl_writeReg,
  output logic [XLEN-1:0] data_writeReg
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  logic            bypass1;
  logic            bypass2;
  logic            wb_hits_rd;
  logic            hazard;
  logic            accept;
  logic            drain;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  // Register file port wiring.
  assign ctrl_readRegA    = in_rs1;
  assign ctrl_readRegB    = in_rs2;
  assign ctrl_writeEnable = wb_valid & (wb_rd != AW'(0));
  assign ctrl_writeReg    = wb_rd;
  assign data_writeReg    = wb_data;

  // Forwarding detection and operand resolution; r0 always reads as zero.
  always_comb begin
    bypass1 = wb_valid & (wb_rd == in_rs1) & (in_rs1 != AW'(0));
    bypass2 = wb_valid & (wb_rd == in_rs2) & (in_rs2 != AW'(0));

    op_a = data_readRegA;
    if (in_rs1 == AW'(0)) begin
      op_a = XLEN'(0);
    end else if (bypass1) begin
      op_a = wb_data;
    end

    op_b = data_readRegB;
    if (in_rs2 == AW'(0)) begin
      op_b = XLEN'(0);
    end else if (bypass2) begin
      op_b = wb_data;
    end
  end

  // A busy source is fine only if its result arrives this cycle. A busy
  // destination (WAW) is fine only if that same write completes now.
  always_comb begin
    wb_hits_rd = wb_valid & (wb_rd == in_rd);
    hazard     = (busy[in_rs1] & ~bypass1)
               | (busy[in_rs2] & ~bypass2)
               | (in_wen & (in_rd != AW'(0)) & busy[in_rd] & ~wb_hits_rd);
    in_ready   = ~hazard & (~out_valid | out_ready);
    accept     = in_valid & in_ready;
    drain      = out_valid & out_ready;
  end

  // Scoreboard next state: the writeback clears first, so a same-index set wins.
  always_comb begin
    busy_next = busy;
    if (wb_valid) begin
      busy_next[wb_rd] = 1'b0;
    end
    if (accept && in_wen && (in_rd != AW'(0))) begin
      busy_next[in_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Output stage: loads only on accept, so a held bundle never sees later writebacks.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      out_valid <= 1'b0;
      out_opA   <= '0;
      out_opB   <= '0;
      out_rd    <= '0;
      out_wen   <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_opA   <= op_a;
        out_opB   <= op_b;
        out_rd    <= in_rd;
        out_wen   <= in_wen;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by random traffic,
// all checked against an architectural model (register array, busy set,
// single output slot) kept in the bench.
module tb_operand_fetch;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        in_valid;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_wen;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_opA, out_opB;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_readRegA, data_readRegB;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int checks = 0;
  int errors = 0;

  // Environment register file, driven only by the DUT write port.
  logic [31:0] rf [32];
  assign data_readRegA = rf[ctrl_readRegA];
  assign data_readRegB = rf[ctrl_readRegB];
  always @(posedge clock) begin
    if (ctrl_writeEnable) rf[ctrl_writeReg] <= data_writeReg;
  end

  always #5 clock = ~clock;

  operand_fetch dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_wen(in_wen), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opA(out_opA), .out_opB(out_opB), .out_rd(out_rd), .out_wen(out_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  // Architectural model.
  logic [31:0] m_reg [32];
  bit          m_busy [32];
  bit          m_valid;
  logic [31:0] m_opA, m_opB;
  logic [4:0]  m_rd;
  logic        m_wen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_operand(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (wb_valid && wb_rd == rs) return wb_data;
    return m_reg[rs];
  endfunction

  function automatic logic m_can_issue();
    logic stall_src, stall_dst;
    stall_src = (m_busy[in_rs1] && !(wb_valid && wb_rd == in_rs1 && in_rs1 != 0))
             || (m_busy[in_rs2] && !(wb_valid && wb_rd == in_rs2 && in_rs2 != 0));
    stall_dst = in_wen && in_rd != 0 && m_busy[in_rd] && !(wb_valid && wb_rd == in_rd);
    return !stall_src && !stall_dst && (!m_valid || out_ready);
  endfunction

  function automatic logic [31:0] m_busy_word();
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = m_busy[i];
    return w;
  endfunction

  task automatic m_clear();
    m_valid = 0; m_opA = 0; m_opB = 0; m_rd = 0; m_wen = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input int rd, input bit wen,
                       input bit wbv, input int wbr, input logic [31:0] wbd, input bit ordy);
    in_valid = v; in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_rd = 5'(rd); in_wen = wen;
    wb_valid = wbv; wb_rd = 5'(wbr); wb_data = wbd; out_ready = ordy;
  endtask

  // One clock: check combinational outputs, advance the model over the edge,
  // then check registered state. Entered and left just after a falling edge.
  task automatic step();
    bit acc;
    #1;
    chk("ready", 32'(in_ready), 32'(ctrl_reset ? 1'b1 : m_can_issue()));
    chk("rsel_a", 32'(ctrl_readRegA), 32'(in_rs1));
    chk("rsel_b", 32'(ctrl_readRegB), 32'(in_rs2));
    chk("wr_en", 32'(ctrl_writeEnable), 32'(wb_valid && wb_rd != 0));
    if (wb_valid && wb_rd != 0) begin
      chk("wr_reg", 32'(ctrl_writeReg), 32'(wb_rd));
      chk("wr_data", data_writeReg, wb_data);
    end
    @(posedge clock);
    if (ctrl_reset) begin
      m_clear();
    end else begin
      acc = in_valid && m_can_issue();
      if (acc) begin
        m_valid = 1; m_opA = m_operand(in_rs1); m_opB = m_operand(in_rs2);
        m_rd = in_rd; m_wen = in_wen;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (wb_valid) m_busy[wb_rd] = 0;
      if (acc && in_wen && in_rd != 0) m_busy[in_rd] = 1;
    end
    if (wb_valid && wb_rd != 0) m_reg[wb_rd] = wb_data;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("busy", dut.busy, m_busy_word());
    if (m_valid) begin
      chk("opA", out_opA, m_opA);
      chk("opB", out_opB, m_opB);
      chk("out_rd", 32'(out_rd), 32'(m_rd));
      chk("out_wen", 32'(out_wen), 32'(m_wen));
    end
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] held_a, held_b;
    ctrl_reset = 1'b1;
    m_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 32'd0, 1);
    @(negedge clock);
    // Fill the register file during reset (write port is independent of reset).
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, 1, i, $urandom, 1);
      step();
    end
    drive(0, 0, 0, 0, 0, 1, 5, 32'h11, 1); step();
    drive(0, 0, 0, 0, 0, 1, 6, 32'h22, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 32'd0, 1);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_opA", out_opA, 32'd0);
    chk("rst_opB", out_opB, 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_wen", 32'(out_wen), 32'd0);
    chk("rst_busy", dut.busy, 32'd0);
    ctrl_reset = 1'b0;
    @(negedge clock);

    // First accept right after reset release.
    drive(1, 5, 6, 7, 1, 0, 0, 32'd0, 1); step();
    chk("s1_opA", out_opA, 32'h11);
    chk("s1_opB", out_opB, 32'h22);
    chk("s1_busy7", 32'(dut.busy[7]), 32'd1);

    // RAW stall on r7, released by the forwarded writeback.
    drive(1, 7, 6, 8, 0, 0, 0, 32'd0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s2_stall", 32'(in_ready), 32'd0);
    end
    drive(1, 7, 6, 8, 0, 1, 7, 32'hABCD, 1); step();
    chk("s2_fwd", out_opA, 32'hABCD);
    chk("s2_busy7", 32'(dut.busy[7]), 32'd0);

    // Backpressure: stage holds, later writebacks must not refresh it.
    drive(1, 5, 6, 10, 1, 0, 0, 32'd0, 1); step();
    held_a = out_opA; held_b = out_opB;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2, 11, 0, 1, 5, $urandom, 0); step();
      chk("s3_hold_a", out_opA, held_a);
      chk("s3_hold_b", out_opB, held_b);
      chk("s3_hold_rd", 32'(out_rd), 32'd10);
    end
    drive(1, 1, 2, 11, 0, 0, 0, 32'd0, 1); step();
    chk("s3_reload", 32'(out_valid), 32'd1);
    chk("s3_reload_rd", 32'(out_rd), 32'd11);

    // r0 never forwards and is never written.
    drive(1, 0, 0, 12, 0, 1, 0, 32'hFFFF, 1);
    #1 chk("s4_we", 32'(ctrl_writeEnable), 32'd0);
    @(negedge clock);
    drive(1, 0, 0, 12, 0, 1, 0, 32'hFFFF, 1); step();
    chk("s4_opA", out_opA, 32'd0);
    chk("s4_opB", out_opB, 32'd0);

    // Set and clear of the same index in one cycle: set wins.
    drive(1, 0, 0, 9, 1, 1, 9, 32'h99, 1); step();
    chk("s5_busy9", 32'(dut.busy[9]), 32'd1);
    drive(0, 0, 0, 0, 0, 1, 9, 32'h9A, 1); step();

    // Reset while a bundle is held and r3 is busy.
    drive(1, 1, 2, 3, 1, 1, 10, 32'h10, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 32'd0, 0); step();
    chk("s6_pre_busy3", 32'(dut.busy[3]), 32'd1);
    ctrl_reset = 1'b1;
    #1;
    chk("s6_valid", 32'(out_valid), 32'd0);
    chk("s6_busy3", 32'(dut.busy[3]), 32'd0);
    step();
    ctrl_reset = 1'b0;
    @(negedge clock);

    // Random traffic on a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom % 4) != 0, $urandom % 8, $urandom % 8, $urandom % 8, $urandom % 2,
            $urandom % 2, $urandom % 8, $urandom, ($urandom % 4) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
